// File: rtl/alu_seq_if.sv
// Operation request / result bus between the controller FSM and alu_seq.
// master = controller side, slave = ALU side.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] accum;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] alu_out_hi;
  logic             busy;
  logic             done;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;
  logic             dz;

  modport master (
    output start, opcode, accum, data,
    input  alu_out, alu_out_hi, busy, done, zero, neg, carry, ovf, dz
  );

  modport slave (
    input  start, opcode, accum, data,
    output alu_out, alu_out_hi, busy, done, zero, neg, carry, ovf, dz
  );
endinterface

// File: rtl/alu_seq.sv
// Parametrised sequential ALU: single-cycle arithmetic/logic ops plus
// multi-cycle unsigned shift-add multiply and restoring divide.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  alu_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_XOR  = 3'b100,
    OP_ABS  = 3'b101,
    OP_MUL  = 3'b110,
    OP_DIV  = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] out_lo;
  logic [WIDTH-1:0] out_hi;
  logic             busy_q;
  logic             done_q;
  logic             zero_q;
  logic             neg_q;
  logic             carry_q;
  logic             ovf_q;
  logic             dz_q;

  op_e              op_in;
  logic             multi_in;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] sc_lo;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_c;
  logic             sc_v;
  logic             sc_dz;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  logic             accept;
  logic             last;
  logic             wr;
  logic [WIDTH-1:0] fin_lo;
  logic [WIDTH-1:0] fin_hi;
  logic             fin_c;
  logic             fin_v;
  logic             fin_dz;

  assign op_in    = op_e'(bus.opcode);
  // DIV by zero is resolved at acceptance and never enters RUN
  assign multi_in = (op_in == OP_MUL) || ((op_in == OP_DIV) && (bus.data != '0));

  // Results for ops that complete at the accepting edge
  always_comb begin
    add_full = {1'b0, bus.accum} + {1'b0, bus.data};
    sub_full = {1'b0, bus.accum} - {1'b0, bus.data};
    abs_a    = bus.accum[WIDTH-1] ? ((~bus.accum) + ONE) : bus.accum;
    sc_lo    = '0;
    sc_hi    = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_dz    = 1'b0;
    case (op_in)
      OP_PASS: sc_lo = bus.accum;
      OP_ADD: begin
        sc_lo = add_full[WIDTH-1:0];
        sc_c  = add_full[WIDTH];
        sc_v  = (bus.accum[WIDTH-1] == bus.data[WIDTH-1]) &&
                (add_full[WIDTH-1] != bus.accum[WIDTH-1]);
      end
      OP_SUB: begin
        sc_lo = sub_full[WIDTH-1:0];
        sc_c  = sub_full[WIDTH];
        sc_v  = (bus.accum[WIDTH-1] != bus.data[WIDTH-1]) &&
                (sub_full[WIDTH-1] != bus.accum[WIDTH-1]);
      end
      OP_AND:  sc_lo = bus.accum & bus.data;
      OP_XOR:  sc_lo = bus.accum ^ bus.data;
      OP_ABS: begin
        sc_lo = abs_a;
        sc_v  = bus.accum[WIDTH-1] && (bus.accum[WIDTH-2:0] == '0);
      end
      OP_DIV: begin
        sc_lo = '1;
        sc_hi = bus.accum;
        sc_dz = 1'b1;
      end
      default: ;
    endcase
  end

  // One iteration; hi_q/lo_q are {partial, multiplier} for MUL and
  // {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    if (op_q == OP_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    accept = (state == S_IDLE) && bus.start;
    last   = (state == S_RUN) && (cnt == CW'(1));
    wr     = (accept && !multi_in) || last;
    if (state == S_RUN) begin
      fin_lo = step_lo;
      fin_hi = step_hi;
      fin_c  = (op_q == OP_MUL) && (step_hi != '0);
      fin_v  = 1'b0;
      fin_dz = 1'b0;
    end else begin
      fin_lo = sc_lo;
      fin_hi = sc_hi;
      fin_c  = sc_c;
      fin_v  = sc_v;
      fin_dz = sc_dz;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      op_q    <= OP_PASS;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt     <= '0;
      out_lo  <= '0;
      out_hi  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr) begin
        out_lo  <= fin_lo;
        out_hi  <= fin_hi;
        zero_q  <= (fin_lo == '0);
        neg_q   <= fin_lo[WIDTH-1];
        carry_q <= fin_c;
        ovf_q   <= fin_v;
        dz_q    <= fin_dz;
        done_q  <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (accept && multi_in) begin
            state  <= S_RUN;
            busy_q <= 1'b1;
            op_q   <= op_in;
            a_q    <= bus.accum;
            b_q    <= bus.data;
            hi_q   <= '0;
            lo_q   <= (op_in == OP_MUL) ? bus.data : bus.accum;
            cnt    <= CW'(WIDTH);
          end
        end
        S_RUN: begin
          hi_q <= step_hi;
          lo_q <= step_lo;
          cnt  <= cnt - CW'(1);
          if (last) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_out    = out_lo;
  assign bus.alu_out_hi = out_hi;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.zero       = zero_q;
  assign bus.neg        = neg_q;
  assign bus.carry      = carry_q;
  assign bus.ovf        = ovf_q;
  assign bus.dz         = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 and WIDTH=16.
// Snapshot flag order: {busy, done, zero, neg, carry, ovf, dz}.
module tb_alu_seq;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  if8 ();
  alu_seq_if #(.WIDTH(16)) if16 ();

  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(if8));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .reset_n(reset_n), .bus(if16));

  int vec  = 0;
  int errs = 0;

  function automatic logic [22:0] snap8();
    return {if8.alu_out, if8.alu_out_hi, if8.busy, if8.done, if8.zero,
            if8.neg, if8.carry, if8.ovf, if8.dz};
  endfunction

  function automatic logic [38:0] snap16();
    return {if16.alu_out, if16.alu_out_hi, if16.busy, if16.done, if16.zero,
            if16.neg, if16.carry, if16.ovf, if16.dz};
  endfunction

  // Called at posedge+1; returns at posedge+1 of the first done (or timeout)
  task automatic run_op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [22:0] obs, output int lat);
    if8.start  = 1'b1;
    if8.opcode = op;
    if8.accum  = a;
    if8.data   = b;
    @(posedge clk); #1;
    if8.start = 1'b0;
    lat = 0;
    while (!if8.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    obs = snap8();
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    reset_n     = 1'b0;
    if8.start   = 1'b1;
    if8.opcode  = 3'b000;
    if8.accum   = 8'h5A;
    if8.data    = 8'h00;
    if16.start  = 1'b0;
    if16.opcode = 3'b000;
    if16.accum  = '0;
    if16.data   = '0;
    #23;
    vec++;
    if (snap8() !== {8'h00, 8'h00, 7'b0010000}) begin
      errs++;
      $display("FAIL reset8: got %h expected %h", snap8(), {8'h00, 8'h00, 7'b0010000});
    end
    vec++;
    if (snap16() !== {16'h0000, 16'h0000, 7'b0010000}) begin
      errs++;
      $display("FAIL reset16: got %h expected %h", snap16(), {16'h0000, 16'h0000, 7'b0010000});
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    obs = snap8();
    vec++;
    if (obs !== {8'h5A, 8'h00, 7'b0100000}) begin
      errs++;
      $display("FAIL first_pass: got %h expected %h", obs, {8'h5A, 8'h00, 7'b0100000});
    end
    @(posedge clk); #1;
    obs = snap8();
    vec++;
    if (obs !== {8'h5A, 8'h00, 7'b0000000}) begin
      errs++;
      $display("FAIL pass_done_drop: got %h expected %h", obs, {8'h5A, 8'h00, 7'b0000000});
    end
  endtask

  // Table entries: {opcode, A, B, expected snapshot}; all single-cycle
  task automatic test_single_cycle();
    logic [41:0] tbl [12] = '{
      {3'd1, 8'hFF, 8'h01, 8'h00, 8'h00, 7'b0110100},
      {3'd1, 8'h7F, 8'h01, 8'h80, 8'h00, 7'b0101010},
      {3'd2, 8'h80, 8'h01, 8'h7F, 8'h00, 7'b0100010},
      {3'd2, 8'h01, 8'h02, 8'hFF, 8'h00, 7'b0101100},
      {3'd3, 8'hA5, 8'h0F, 8'h05, 8'h00, 7'b0100000},
      {3'd3, 8'hF0, 8'h0F, 8'h00, 8'h00, 7'b0110000},
      {3'd4, 8'hA5, 8'h5A, 8'hFF, 8'h00, 7'b0101000},
      {3'd5, 8'hFB, 8'h33, 8'h05, 8'h00, 7'b0100000},
      {3'd5, 8'h80, 8'h33, 8'h80, 8'h00, 7'b0101010},
      {3'd5, 8'h05, 8'h33, 8'h05, 8'h00, 7'b0100000},
      {3'd0, 8'h80, 8'hFF, 8'h80, 8'h00, 7'b0101000},
      {3'd7, 8'h2A, 8'h00, 8'hFF, 8'h2A, 7'b0101001}
    };
    logic [22:0] obs;
    int lat;
    for (int i = 0; i < 12; i++) begin
      run_op8(tbl[i][41:39], tbl[i][38:31], tbl[i][30:23], obs, lat);
      vec++;
      if (obs !== tbl[i][22:0] || lat != 0) begin
        errs++;
        $display("FAIL single_cycle[%0d] op=%0d: got %h lat %0d expected %h lat 0",
                 i, tbl[i][41:39], obs, lat, tbl[i][22:0]);
      end
    end
  endtask

  task automatic test_mul();
    int busy_cnt = 0;
    int early_done = 0;
    int k = 0;
    logic [22:0] obs;
    if8.start  = 1'b1;
    if8.opcode = 3'd6;
    if8.accum  = 8'hFF;
    if8.data   = 8'hFF;
    @(posedge clk); #1;
    if8.start = 1'b0;
    while (if8.busy && k < 40) begin
      busy_cnt++;
      if (if8.done) early_done++;
      if (k == 3) begin
        if8.start  = 1'b1;
        if8.opcode = 3'd1;
        if8.accum  = 8'h11;
        if8.data   = 8'h22;
      end else if (k == 4) begin
        if8.start = 1'b0;
        if8.accum = 8'h00;
        if8.data  = 8'h00;
      end
      @(posedge clk); #1;
      k++;
    end
    vec++;
    if (busy_cnt != 8 || early_done != 0) begin
      errs++;
      $display("FAIL mul_busy: got busy %0d cycles, %0d early done; expected 8, 0",
               busy_cnt, early_done);
    end
    obs = snap8();
    vec++;
    if (obs !== {8'h01, 8'hFE, 7'b0100100}) begin
      errs++;
      $display("FAIL mul_ff_ff: got %h expected %h", obs, {8'h01, 8'hFE, 7'b0100100});
    end
    @(posedge clk); #1;
    obs = snap8();
    vec++;
    if (obs !== {8'h01, 8'hFE, 7'b0000100}) begin
      errs++;
      $display("FAIL mul_hold: got %h expected %h", obs, {8'h01, 8'hFE, 7'b0000100});
    end
  endtask

  task automatic test_div();
    logic [22:0] obs;
    int lat;
    run_op8(3'd7, 8'd200, 8'd7, obs, lat);
    vec++;
    if (obs !== {8'h1C, 8'h04, 7'b0100000} || lat != 8) begin
      errs++;
      $display("FAIL div_200_7: got %h lat %0d expected %h lat 8",
               obs, lat, {8'h1C, 8'h04, 7'b0100000});
    end
    run_op8(3'd7, 8'hFF, 8'hFF, obs, lat);
    vec++;
    if (obs !== {8'h01, 8'h00, 7'b0100000} || lat != 8) begin
      errs++;
      $display("FAIL div_ff_ff: got %h lat %0d expected %h lat 8",
               obs, lat, {8'h01, 8'h00, 7'b0100000});
    end
    run_op8(3'd7, 8'h2A, 8'h00, obs, lat);
    vec++;
    if (obs !== {8'hFF, 8'h2A, 7'b0101001} || lat != 0) begin
      errs++;
      $display("FAIL div_by_zero: got %h lat %0d expected %h lat 0",
               obs, lat, {8'hFF, 8'h2A, 7'b0101001});
    end
  endtask

  task automatic test_back_to_back();
    logic [22:0] obs;
    int lat = 0;
    if8.start  = 1'b1;
    if8.opcode = 3'd1;
    if8.accum  = 8'h01;
    if8.data   = 8'h02;
    @(posedge clk); #1;
    obs = snap8();
    vec++;
    if (obs !== {8'h03, 8'h00, 7'b0100000}) begin
      errs++;
      $display("FAIL b2b_add: got %h expected %h", obs, {8'h03, 8'h00, 7'b0100000});
    end
    if8.opcode = 3'd4;
    if8.accum  = 8'h0F;
    if8.data   = 8'hF0;
    @(posedge clk); #1;
    obs = snap8();
    vec++;
    if (obs !== {8'hFF, 8'h00, 7'b0101000}) begin
      errs++;
      $display("FAIL b2b_xor: got %h expected %h", obs, {8'hFF, 8'h00, 7'b0101000});
    end
    // start stays high through the MUL; the PASS must land at edge N+9
    if8.opcode = 3'd6;
    if8.accum  = 8'h03;
    if8.data   = 8'h05;
    @(posedge clk); #1;
    if8.opcode = 3'd0;
    if8.accum  = 8'h77;
    if8.data   = 8'h00;
    while (!if8.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    obs = snap8();
    vec++;
    if (obs !== {8'h0F, 8'h00, 7'b0100000} || lat != 8) begin
      errs++;
      $display("FAIL b2b_mul: got %h lat %0d expected %h lat 8",
               obs, lat, {8'h0F, 8'h00, 7'b0100000});
    end
    @(posedge clk); #1;
    if8.start = 1'b0;
    obs = snap8();
    vec++;
    if (obs !== {8'h77, 8'h00, 7'b0100000}) begin
      errs++;
      $display("FAIL b2b_after_mul: got %h expected %h", obs, {8'h77, 8'h00, 7'b0100000});
    end
  endtask

  task automatic test_reset_mid_op();
    logic [22:0] obs;
    int done_cnt = 0;
    if8.start  = 1'b1;
    if8.opcode = 3'd6;
    if8.accum  = 8'hFF;
    if8.data   = 8'hFF;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    reset_n = 1'b0;
    #1;
    obs = snap8();
    vec++;
    if (obs !== {8'h00, 8'h00, 7'b0010000}) begin
      errs++;
      $display("FAIL reset_mid_op: got %h expected %h", obs, {8'h00, 8'h00, 7'b0010000});
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (if8.done || if8.busy) done_cnt++;
    end
    obs = snap8();
    vec++;
    if (obs !== {8'h00, 8'h00, 7'b0010000} || done_cnt != 0) begin
      errs++;
      $display("FAIL post_reset_quiet: got %h with %0d done/busy cycles, expected %h with 0",
               obs, done_cnt, {8'h00, 8'h00, 7'b0010000});
    end
  endtask

  task automatic test_width16();
    logic [38:0] obs;
    int lat = 0;
    if16.start  = 1'b1;
    if16.opcode = 3'd6;
    if16.accum  = 16'hFFFF;
    if16.data   = 16'h0002;
    @(posedge clk); #1;
    if16.start = 1'b0;
    while (!if16.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    obs = snap16();
    vec++;
    if (obs !== {16'hFFFE, 16'h0001, 7'b0101100} || lat != 16) begin
      errs++;
      $display("FAIL mul16: got %h lat %0d expected %h lat 16",
               obs, lat, {16'hFFFE, 16'h0001, 7'b0101100});
    end
    lat = 0;
    if16.start  = 1'b1;
    if16.opcode = 3'd7;
    if16.accum  = 16'hFFFF;
    if16.data   = 16'h0010;
    @(posedge clk); #1;
    if16.start = 1'b0;
    while (!if16.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    obs = snap16();
    vec++;
    if (obs !== {16'h0FFF, 16'h000F, 7'b0100000} || lat != 16) begin
      errs++;
      $display("FAIL div16: got %h lat %0d expected %h lat 16",
               obs, lat, {16'h0FFF, 16'h000F, 7'b0100000});
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid_op();
    test_width16();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU, the next generation of the team's 8-bit accumulator ALU. Supports a configurable data width, a start/busy/done handshake, multi-cycle unsigned multiply and divide with double-width results, and a full flag set (zero, negative, carry, overflow, divide-by-zero). It sits between the accumulator/operand registers and the controller FSM. The controller issues an operation with `start` and waits for `done`.

## Interface

Parameters:
- `WIDTH`, 8: operand and result width; must be at least 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request an operation; sampled only while `busy`=0.
- `opcode` in 3: 000 PASS, 001 ADD, 010 SUB, 011 AND, 100 XOR, 101 ABS, 110 MUL, 111 DIV.
- `accum` in WIDTH: operand A.
- `data` in WIDTH: operand B.
- `alu_out` out WIDTH: primary result (low product / quotient).
- `alu_out_hi` out WIDTH: high product / remainder; 0 for other ops.
- `busy` out 1: MUL/DIV in progress.
- `done` out 1: one-cycle pulse when results and flags update.
- `zero` out 1: `alu_out` == 0.
- `neg` out 1: `alu_out[WIDTH-1]`.
- `carry` out 1: see Operation.
- `ovf` out 1: signed overflow.
- `dz` out 1: divide by zero.

## Operation

- **Capture:** at the edge where `start`=1 and `busy`=0, `opcode`, `accum` and `data` are latched internally. Input changes after that edge do not affect the operation.
- **start while busy:** ignored and not queued.
- **Hold:** outputs change only on a `done` edge or on reset. Between updates they hold their last values.
- **PASS:** `alu_out`=A. C=V=0.
- **ADD:** `alu_out`=A+B mod 2^WIDTH. C=carry-out of the WIDTH-bit sum. V=signed overflow.
- **SUB:** `alu_out`=A−B mod 2^WIDTH. C=borrow, i.e. 1 when A<B unsigned. V=signed overflow.
- **AND, XOR:** bitwise result. C=V=0.
- **ABS:** two's-complement absolute value of A. For A = the most-negative value (1000..0): `alu_out`=A and V=1. Otherwise V=0. C=0.
- **MUL:** unsigned shift-add, one partial product per cycle, WIDTH iterations. The 2·WIDTH-bit product is split into {`alu_out_hi`,`alu_out`}. C=1 iff `alu_out_hi`≠0. V=0.
- **DIV:** unsigned restoring division, one quotient bit per cycle, WIDTH iterations. `alu_out`=quotient, `alu_out_hi`=remainder. C=V=0.
- **DIV with B=0:** completes as a single-cycle op. `alu_out`=all ones, `alu_out_hi`=A, `dz`=1.
- **dz:** 0 for every other result.
- **zero, neg:** always derived from the new `alu_out`.
- **FSM states:**
  - IDLE → (start, single-cycle op or DIV by 0) → IDLE with `done` pulse.
  - IDLE → (start, MUL/DIV) → RUN; iteration counter loaded with WIDTH.
  - RUN: one iteration per edge, counter decrements. At the edge where the last iteration completes: results written, `done` pulsed, → IDLE.
- **Reset (asynchronous, any state, including mid-MUL/DIV):**
  - The operation is aborted; no `done` is produced.
  - FSM → IDLE.
  - `alu_out`=0, `alu_out_hi`=0, `busy`=0, `done`=0, `zero`=1, `neg`=`carry`=`ovf`=`dz`=0.

## Timing

- **Single-cycle ops:** start accepted at edge N. Results, flags and `done`=1 become visible after edge N. `done` returns to 0 after edge N+1 unless a new op completes there.
- **MUL/DIV (B≠0):** start accepted at edge N. `busy`=1 after edge N. Results, flags and `done`=1 become visible after edge N+WIDTH, where `busy` returns to 0.
- **Latency:** total 8 cycles for WIDTH=8.
- **Back-to-back:**
  - A new `start` is accepted at the same edge at which `busy` is seen 0. This gives one op per cycle for single-cycle ops.
  - After a MUL/DIV, the earliest next acceptance is edge N+WIDTH+1.
- **Reset release:** `reset_n` deasserts asynchronously. The first `start` is sampled at the first rising edge with `reset_n`=1.

## Test plan

- **Reset values:** WIDTH=8, hold `reset_n`=0 → all outputs at reset values, `zero`=1. Release, then PASS A=0x5A → `alu_out`=0x5A, `zero`=0, `done` high for exactly one cycle after the start edge.
- **ADD/SUB flags:**
  - ADD 0xFF+0x01 → 0x00, zero=1, carry=1, ovf=0.
  - ADD 0x7F+0x01 → 0x80, neg=1, ovf=1.
  - SUB 0x80−0x01 → 0x7F, ovf=1, carry=0.
  - SUB 0x01−0x02 → 0xFF, carry=1.
- **ABS:** A=0xFB → 0x05. A=0x80 → 0x80, ovf=1. A=0x05 → 0x05.
- **MUL:** 0xFF×0xFF → `alu_out`=0x01, `alu_out_hi`=0xFE, carry=1. `busy` high for exactly 8 cycles. `done` after edge N+8. A `start` pulsed mid-operation is ignored and the inputs changed mid-operation do not alter the result.
- **DIV:**
  - 200÷7 → `alu_out`=0x1C, `alu_out_hi`=0x04, dz=0, 8-cycle latency.
  - 0x2A÷0 → `alu_out`=0xFF, `alu_out_hi`=0x2A, dz=1, `done` after edge N (one cycle).
- **Reset mid-operation:** start MUL, assert `reset_n`=0 asynchronously (between edges) at cycle 4 → outputs at reset values immediately, no `done` afterwards. Re-run with WIDTH=16, 0xFFFF×0x0002 → `alu_out`=0xFFFE, `alu_out_hi`=0x0001, 16-cycle latency.
